// File: rtl/lsu_mem_pkg.sv
// Shared encodings and helpers for the lsu_mem load/store stage.
package lsu_mem_pkg;

    localparam int LSU_XLEN   = 64;
    localparam int LSU_INFO_W = 6;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10
    } lsu_state_e;

    // Encoding 2'b11 is reserved and behaves like a non-memory op.
    function automatic logic is_mem_op(input logic [1:0] op);
        return !((op == MEM_OP_NONE) || (op == 2'b11));
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lane);
        case (size)
            SIZE_B:  return 1'b1;
            SIZE_H:  return (lane[0] == 1'b0);
            SIZE_W:  return (lane[1:0] == 2'b00);
            default: return (lane == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_align.sv
// Byte-lane steering: load extract/extend and store replicate/write-mask generation.
module lsu_mem_align
    import lsu_mem_pkg::*;
(
    input  logic [1:0]          size,
    input  logic                is_unsigned,
    input  logic [2:0]          lane,
    input  logic [LSU_XLEN-1:0] sdata,
    input  logic [LSU_XLEN-1:0] rdata,
    output logic [LSU_XLEN-1:0] ldata,
    output logic [LSU_XLEN-1:0] wdata,
    output logic [7:0]          wmask
);

    logic [LSU_XLEN-1:0] field;
    logic [7:0]          mask_base;

    assign field = rdata >> {lane, 3'b000};

    always_comb begin
        ldata     = '0;
        wdata     = '0;
        mask_base = 8'h00;
        case (size)
            SIZE_B: begin
                ldata     = is_unsigned ? {56'd0, field[7:0]} : {{56{field[7]}}, field[7:0]};
                wdata     = {8{sdata[7:0]}};
                mask_base = 8'h01;
            end
            SIZE_H: begin
                ldata     = is_unsigned ? {48'd0, field[15:0]} : {{48{field[15]}}, field[15:0]};
                wdata     = {4{sdata[15:0]}};
                mask_base = 8'h03;
            end
            SIZE_W: begin
                ldata     = is_unsigned ? {32'd0, field[31:0]} : {{32{field[31]}}, field[31:0]};
                wdata     = {2{sdata[31:0]}};
                mask_base = 8'h0F;
            end
            default: begin
                ldata     = field;
                wdata     = sdata;
                mask_base = 8'hFF;
            end
        endcase
    end

    // Lanes shifted past byte 7 fall off; only reachable on misaligned accesses.
    assign wmask = mask_base << lane;

endmodule

// File: rtl/lsu_mem.sv
// Load/store stage between exu and wbu on a req/gnt/rvalid data-memory bus.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned mem ops flagged, no bus access).
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   LSU_IDLE | ready for a new op; non-mem ops retire from here in 1 cycle
//   LSU_REQ  | memory request held on the bus until gnt
//   LSU_WAIT | load granted, waiting for rvalid
module lsu_mem
    import lsu_mem_pkg::*;
#(
    parameter int XLEN   = LSU_XLEN,
    parameter int INFO_W = LSU_INFO_W
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              exu_lsu_valid,
    output logic              lsu_exu_ready,
    input  logic [1:0]        exu_lsu_mem_op,
    input  logic [1:0]        exu_lsu_size,
    input  logic              exu_lsu_unsigned,
    input  logic [XLEN-1:0]   exu_lsu_result,
    input  logic [XLEN-1:0]   exu_lsu_sdata,
    input  logic [4:0]        exu_lsu_dst,
    input  logic [INFO_W-1:0] exu_lsu_type,
    input  logic [XLEN-1:0]   exu_lsu_pc,
    output logic              lsu_mem_req,
    output logic              lsu_mem_we,
    output logic [XLEN-1:0]   lsu_mem_addr,
    output logic [XLEN-1:0]   lsu_mem_wdata,
    output logic [7:0]        lsu_mem_wmask,
    input  logic              mem_lsu_gnt,
    input  logic              mem_lsu_rvalid,
    input  logic [XLEN-1:0]   mem_lsu_rdata,
    output logic              lsu_wbu_valid,
    output logic [4:0]        lsu_wbu_dst,
    output logic [XLEN-1:0]   wbu_dst_data,
    output logic [INFO_W-1:0] lsu_wbu_type,
    output logic [XLEN-1:0]   lsu_wbu_pc,
    output logic              lsu_wbu_misalign
);

    lsu_state_e        state;
    lsu_state_e        state_nxt;

    logic [1:0]        lat_mem_op;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [XLEN-1:0]   lat_addr;
    logic [XLEN-1:0]   lat_sdata;
    logic [4:0]        lat_dst;
    logic [INFO_W-1:0] lat_type;
    logic [XLEN-1:0]   lat_pc;

    logic              accept;
    logic              acc_mem;
    logic              acc_misalign;
    logic              lat_store;
    logic [XLEN-1:0]   load_data;

    assign accept    = exu_lsu_valid && lsu_exu_ready;
    assign acc_mem   = accept && is_mem_op(exu_lsu_mem_op);
    assign lat_store = (lat_mem_op == MEM_OP_STORE);

`ifdef LSU_MISALIGN_CHECK_EN
    assign acc_misalign = acc_mem && !is_aligned(exu_lsu_size, exu_lsu_result[2:0]);
`else
    assign acc_misalign = 1'b0;
`endif

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: if (acc_mem && !acc_misalign) state_nxt = LSU_REQ;
            LSU_REQ:  if (mem_lsu_gnt)    state_nxt = lat_store ? LSU_IDLE : LSU_WAIT;
            LSU_WAIT: if (mem_lsu_rvalid) state_nxt = LSU_IDLE;
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    always_comb begin
        lsu_exu_ready = (state == LSU_IDLE);
        lsu_mem_req   = (state == LSU_REQ);
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            lat_mem_op   <= MEM_OP_NONE;
            lat_size     <= SIZE_B;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_sdata    <= '0;
            lat_dst      <= '0;
            lat_type     <= '0;
            lat_pc       <= '0;
        end else if (accept) begin
            lat_mem_op   <= exu_lsu_mem_op;
            lat_size     <= exu_lsu_size;
            lat_unsigned <= exu_lsu_unsigned;
            lat_addr     <= exu_lsu_result;
            lat_sdata    <= exu_lsu_sdata;
            lat_dst      <= exu_lsu_dst;
            lat_type     <= exu_lsu_type;
            lat_pc       <= exu_lsu_pc;
        end
    end

    assign lsu_mem_we   = lat_store;
    assign lsu_mem_addr = {lat_addr[XLEN-1:3], 3'b000};

    lsu_mem_align u_align (
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .lane        (lat_addr[2:0]),
        .sdata       (lat_sdata),
        .rdata       (mem_lsu_rdata),
        .ldata       (load_data),
        .wdata       (lsu_mem_wdata),
        .wmask       (lsu_mem_wmask)
    );

    // Accept only happens in IDLE, so the branches below are mutually exclusive.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            lsu_wbu_valid    <= 1'b0;
            lsu_wbu_misalign <= 1'b0;
            lsu_wbu_dst      <= '0;
            wbu_dst_data     <= '0;
            lsu_wbu_type     <= '0;
            lsu_wbu_pc       <= '0;
        end else begin
            lsu_wbu_valid    <= 1'b0;
            lsu_wbu_misalign <= 1'b0;
            if (accept && !acc_mem) begin
                lsu_wbu_valid <= 1'b1;
                lsu_wbu_dst   <= exu_lsu_dst;
                wbu_dst_data  <= exu_lsu_result;
                lsu_wbu_type  <= exu_lsu_type;
                lsu_wbu_pc    <= exu_lsu_pc;
            end else if (acc_misalign) begin
                lsu_wbu_valid    <= 1'b1;
                lsu_wbu_misalign <= 1'b1;
                lsu_wbu_dst      <= '0;
                wbu_dst_data     <= '0;
                lsu_wbu_type     <= exu_lsu_type;
                lsu_wbu_pc       <= exu_lsu_pc;
            end else if ((state == LSU_REQ) && mem_lsu_gnt && lat_store) begin
                lsu_wbu_valid <= 1'b1;
                lsu_wbu_dst   <= lat_dst;
                wbu_dst_data  <= '0;
                lsu_wbu_type  <= lat_type;
                lsu_wbu_pc    <= lat_pc;
            end else if ((state == LSU_WAIT) && mem_lsu_rvalid) begin
                lsu_wbu_valid <= 1'b1;
                lsu_wbu_dst   <= lat_dst;
                wbu_dst_data  <= load_data;
                lsu_wbu_type  <= lat_type;
                lsu_wbu_pc    <= lat_pc;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: pass-through, loads, stores, reset mid-op, misalign handling.
module tb_lsu_mem;

    logic        core_clk;
    logic        core_rst;
    logic        exu_lsu_valid;
    logic        lsu_exu_ready;
    logic [1:0]  exu_lsu_mem_op;
    logic [1:0]  exu_lsu_size;
    logic        exu_lsu_unsigned;
    logic [63:0] exu_lsu_result;
    logic [63:0] exu_lsu_sdata;
    logic [4:0]  exu_lsu_dst;
    logic [5:0]  exu_lsu_type;
    logic [63:0] exu_lsu_pc;
    logic        lsu_mem_req;
    logic        lsu_mem_we;
    logic [63:0] lsu_mem_addr;
    logic [63:0] lsu_mem_wdata;
    logic [7:0]  lsu_mem_wmask;
    logic        mem_lsu_gnt;
    logic        mem_lsu_rvalid;
    logic [63:0] mem_lsu_rdata;
    logic        lsu_wbu_valid;
    logic [4:0]  lsu_wbu_dst;
    logic [63:0] wbu_dst_data;
    logic [5:0]  lsu_wbu_type;
    logic [63:0] lsu_wbu_pc;
    logic        lsu_wbu_misalign;

    int total = 0;
    int bad   = 0;

    lsu_mem dut (
        .core_clk         (core_clk),
        .core_rst         (core_rst),
        .exu_lsu_valid    (exu_lsu_valid),
        .lsu_exu_ready    (lsu_exu_ready),
        .exu_lsu_mem_op   (exu_lsu_mem_op),
        .exu_lsu_size     (exu_lsu_size),
        .exu_lsu_unsigned (exu_lsu_unsigned),
        .exu_lsu_result   (exu_lsu_result),
        .exu_lsu_sdata    (exu_lsu_sdata),
        .exu_lsu_dst      (exu_lsu_dst),
        .exu_lsu_type     (exu_lsu_type),
        .exu_lsu_pc       (exu_lsu_pc),
        .lsu_mem_req      (lsu_mem_req),
        .lsu_mem_we       (lsu_mem_we),
        .lsu_mem_addr     (lsu_mem_addr),
        .lsu_mem_wdata    (lsu_mem_wdata),
        .lsu_mem_wmask    (lsu_mem_wmask),
        .mem_lsu_gnt      (mem_lsu_gnt),
        .mem_lsu_rvalid   (mem_lsu_rvalid),
        .mem_lsu_rdata    (mem_lsu_rdata),
        .lsu_wbu_valid    (lsu_wbu_valid),
        .lsu_wbu_dst      (lsu_wbu_dst),
        .wbu_dst_data     (wbu_dst_data),
        .lsu_wbu_type     (lsu_wbu_type),
        .lsu_wbu_pc       (lsu_wbu_pc),
        .lsu_wbu_misalign (lsu_wbu_misalign)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] rdata, input logic [63:0] exp,
                           input logic [4:0] dst);
        logic [63:0] exp_addr;
        exp_addr = {addr[63:3], 3'b000};
        exu_lsu_valid    = 1'b1;
        exu_lsu_mem_op   = 2'b01;
        exu_lsu_size     = size;
        exu_lsu_unsigned = uns;
        exu_lsu_result   = addr;
        exu_lsu_dst      = dst;
        exu_lsu_type     = 6'h21;
        exu_lsu_pc       = addr ^ 64'hF00;
        tick();
        exu_lsu_valid = 1'b0;
        chk({tag, "_req"},   lsu_mem_req,   1'b1);
        chk({tag, "_we"},    lsu_mem_we,    1'b0);
        chk({tag, "_addr"},  lsu_mem_addr,  exp_addr);
        chk({tag, "_ready"}, lsu_exu_ready, 1'b0);
        // rvalid coincident with gnt while in REQ must not retire the load
        mem_lsu_gnt    = 1'b1;
        mem_lsu_rvalid = 1'b1;
        mem_lsu_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        mem_lsu_gnt    = 1'b0;
        mem_lsu_rvalid = 1'b0;
        chk({tag, "_noearly"}, lsu_wbu_valid, 1'b0);
        chk({tag, "_reqdrop"}, lsu_mem_req,   1'b0);
        tick();
        chk({tag, "_wait"}, lsu_wbu_valid, 1'b0);
        mem_lsu_rvalid = 1'b1;
        mem_lsu_rdata  = rdata;
        tick();
        mem_lsu_rvalid = 1'b0;
        chk({tag, "_valid"}, lsu_wbu_valid,    1'b1);
        chk({tag, "_data"},  wbu_dst_data,     exp);
        chk({tag, "_dst"},   lsu_wbu_dst,      dst);
        chk({tag, "_pc"},    lsu_wbu_pc,       addr ^ 64'hF00);
        chk({tag, "_mis"},   lsu_wbu_misalign, 1'b0);
        chk({tag, "_rdy1"},  lsu_exu_ready,    1'b1);
        tick();
        chk({tag, "_pulse"}, lsu_wbu_valid, 1'b0);
    endtask

    task automatic do_store(input string tag, input logic [63:0] addr, input logic [1:0] size,
                            input logic [63:0] sdata, input logic [63:0] exp_wdata,
                            input logic [7:0] exp_wmask, input int gnt_delay,
                            input logic [4:0] dst);
        logic [63:0] exp_addr;
        exp_addr = {addr[63:3], 3'b000};
        exu_lsu_valid    = 1'b1;
        exu_lsu_mem_op   = 2'b10;
        exu_lsu_size     = size;
        exu_lsu_unsigned = 1'b0;
        exu_lsu_result   = addr;
        exu_lsu_sdata    = sdata;
        exu_lsu_dst      = dst;
        exu_lsu_type     = 6'h0A;
        exu_lsu_pc       = 64'h8000;
        tick();
        exu_lsu_valid = 1'b0;
        for (int i = 0; i < gnt_delay; i++) begin
            chk({tag, "_hreq"},   lsu_mem_req,   1'b1);
            chk({tag, "_haddr"},  lsu_mem_addr,  exp_addr);
            chk({tag, "_hready"}, lsu_exu_ready, 1'b0);
            chk({tag, "_hvalid"}, lsu_wbu_valid, 1'b0);
            tick();
        end
        chk({tag, "_req"},   lsu_mem_req,   1'b1);
        chk({tag, "_we"},    lsu_mem_we,    1'b1);
        chk({tag, "_addr"},  lsu_mem_addr,  exp_addr);
        chk({tag, "_wdata"}, lsu_mem_wdata, exp_wdata);
        chk({tag, "_wmask"}, lsu_mem_wmask, exp_wmask);
        chk({tag, "_ready"}, lsu_exu_ready, 1'b0);
        mem_lsu_gnt = 1'b1;
        tick();
        mem_lsu_gnt = 1'b0;
        chk({tag, "_valid"}, lsu_wbu_valid, 1'b1);
        chk({tag, "_data"},  wbu_dst_data,  64'h0);
        chk({tag, "_dst"},   lsu_wbu_dst,   dst);
        chk({tag, "_type"},  lsu_wbu_type,  6'h0A);
        chk({tag, "_reqlo"}, lsu_mem_req,   1'b0);
        chk({tag, "_rdy1"},  lsu_exu_ready, 1'b1);
        tick();
        chk({tag, "_pulse"}, lsu_wbu_valid, 1'b0);
    endtask

    initial begin
        core_rst         = 1'b1;
        exu_lsu_valid    = 1'b0;
        exu_lsu_mem_op   = 2'b00;
        exu_lsu_size     = 2'b00;
        exu_lsu_unsigned = 1'b0;
        exu_lsu_result   = '0;
        exu_lsu_sdata    = '0;
        exu_lsu_dst      = '0;
        exu_lsu_type     = '0;
        exu_lsu_pc       = '0;
        mem_lsu_gnt      = 1'b0;
        mem_lsu_rvalid   = 1'b0;
        mem_lsu_rdata    = '0;
        tick();
        tick();
        core_rst = 1'b0;

        chk("rst_ready", lsu_exu_ready,    1'b1);
        chk("rst_req",   lsu_mem_req,      1'b0);
        chk("rst_valid", lsu_wbu_valid,    1'b0);
        chk("rst_mis",   lsu_wbu_misalign, 1'b0);
        chk("rst_data",  wbu_dst_data,     64'h0);
        chk("rst_dst",   lsu_wbu_dst,      5'h0);
        chk("rst_type",  lsu_wbu_type,     6'h0);
        chk("rst_pc",    lsu_wbu_pc,       64'h0);

        // Non-memory pass-through, back to back
        exu_lsu_valid  = 1'b1;
        exu_lsu_mem_op = 2'b00;
        exu_lsu_result = 64'h1234;
        exu_lsu_dst    = 5'd5;
        exu_lsu_type   = 6'h11;
        exu_lsu_pc     = 64'h100;
        tick();
        chk("add_valid", lsu_wbu_valid, 1'b1);
        chk("add_data",  wbu_dst_data,  64'h1234);
        chk("add_dst",   lsu_wbu_dst,   5'd5);
        chk("add_type",  lsu_wbu_type,  6'h11);
        chk("add_pc",    lsu_wbu_pc,    64'h100);
        chk("add_ready", lsu_exu_ready, 1'b1);
        chk("add_noreq", lsu_mem_req,   1'b0);
        exu_lsu_mem_op = 2'b11;
        exu_lsu_result = 64'hCAFE_0000_5678;
        exu_lsu_dst    = 5'd7;
        exu_lsu_pc     = 64'h104;
        tick();
        chk("b2b_valid",  lsu_wbu_valid, 1'b1);
        chk("b2b_data",   wbu_dst_data,  64'hCAFE_0000_5678);
        chk("b2b_dst",    lsu_wbu_dst,   5'd7);
        chk("b2b_pc",     lsu_wbu_pc,    64'h104);
        chk("op11_noreq", lsu_mem_req,   1'b0);
        exu_lsu_valid = 1'b0;
        tick();
        chk("b2b_idle", lsu_wbu_valid, 1'b0);

        // Loads
        do_load("lb",   64'h1003, 2'b00, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 5'd3);
        do_load("lbu",  64'h1003, 2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 5'd4);
        do_load("lb0",  64'h1000, 2'b00, 1'b0, 64'h1111_2222_3333_447F, 64'h0000_0000_0000_007F, 5'd6);
        do_load("lh",   64'h1006, 2'b01, 1'b0, 64'h8001_2345_6789_ABCD, 64'hFFFF_FFFF_FFFF_8001, 5'd8);
        do_load("lhu",  64'h1006, 2'b01, 1'b1, 64'h8001_2345_6789_ABCD, 64'h0000_0000_0000_8001, 5'd9);
        do_load("lw",   64'h1004, 2'b10, 1'b0, 64'hF000_0000_1234_5678, 64'hFFFF_FFFF_F000_0000, 5'd10);
        do_load("lwu",  64'h1004, 2'b10, 1'b1, 64'hF000_0000_1234_5678, 64'h0000_0000_F000_0000, 5'd11);
        do_load("ld",   64'h1008, 2'b11, 1'b1, 64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF, 5'd12);

        // Stores
        do_store("sw", 64'h2004, 2'b10, 64'hFFFF_0000_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0, 3, 5'd9);
        do_store("sb", 64'h2007, 2'b00, 64'h0000_0000_0000_12AB, 64'hABAB_ABAB_ABAB_ABAB, 8'h80, 0, 5'd1);
        do_store("sh", 64'h2002, 2'b01, 64'h1234_5678_9ABC_BEEF, 64'hBEEF_BEEF_BEEF_BEEF, 8'h0C, 1, 5'd2);
        do_store("sd", 64'h2008, 2'b11, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 5'd3);

        // Reset while a load is waiting for rvalid
        exu_lsu_valid  = 1'b1;
        exu_lsu_mem_op = 2'b01;
        exu_lsu_size   = 2'b11;
        exu_lsu_result = 64'h3008;
        exu_lsu_dst    = 5'd13;
        tick();
        exu_lsu_valid = 1'b0;
        mem_lsu_gnt   = 1'b1;
        tick();
        mem_lsu_gnt = 1'b0;
        chk("rstw_inwait", lsu_exu_ready, 1'b0);
        core_rst = 1'b1;
        tick();
        core_rst = 1'b0;
        chk("rstw_req",   lsu_mem_req,   1'b0);
        chk("rstw_valid", lsu_wbu_valid, 1'b0);
        chk("rstw_ready", lsu_exu_ready, 1'b1);
        chk("rstw_data",  wbu_dst_data,  64'h0);
        mem_lsu_rvalid = 1'b1;
        mem_lsu_rdata  = 64'h5555_5555_5555_5555;
        tick();
        mem_lsu_rvalid = 1'b0;
        chk("stray_rvalid", lsu_wbu_valid, 1'b0);
        chk("stray_rvdata", wbu_dst_data,  64'h0);
        mem_lsu_gnt = 1'b1;
        tick();
        mem_lsu_gnt = 1'b0;
        chk("stray_gnt_req",   lsu_mem_req,   1'b0);
        chk("stray_gnt_valid", lsu_wbu_valid, 1'b0);
        chk("stray_gnt_ready", lsu_exu_ready, 1'b1);

`ifdef LSU_MISALIGN_CHECK_EN
        exu_lsu_valid    = 1'b1;
        exu_lsu_mem_op   = 2'b01;
        exu_lsu_size     = 2'b10;
        exu_lsu_unsigned = 1'b0;
        exu_lsu_result   = 64'h1002;
        exu_lsu_dst      = 5'd14;
        exu_lsu_type     = 6'h33;
        exu_lsu_pc       = 64'h200;
        tick();
        exu_lsu_valid = 1'b0;
        chk("mis_noreq", lsu_mem_req,      1'b0);
        chk("mis_ready", lsu_exu_ready,    1'b1);
        chk("mis_valid", lsu_wbu_valid,    1'b1);
        chk("mis_flag",  lsu_wbu_misalign, 1'b1);
        chk("mis_dst",   lsu_wbu_dst,      5'd0);
        chk("mis_data",  wbu_dst_data,     64'h0);
        chk("mis_pc",    lsu_wbu_pc,       64'h200);
        tick();
        chk("mis_pulse", lsu_wbu_valid,    1'b0);
        chk("mis_clr",   lsu_wbu_misalign, 1'b0);
`else
        do_load("lw_mis", 64'h1002, 2'b10, 1'b0, 64'h0000_ABCD_1234_0000, 64'hFFFF_FFFF_ABCD_1234, 5'd14);
        do_store("sh_l7", 64'h2007, 2'b01, 64'h0000_0000_0000_BEEF, 64'hBEEF_BEEF_BEEF_BEEF, 8'h80, 0, 5'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
